// File: rtl/cpu_10bits.sv
// Single-cycle 10-bit CPU core: PC fetch, 2-bank x 4 register file, ALU and 1024-word data RAM.
// The instruction ROM is external and is read combinationally at the current pc.
module cpu_10bits #(
  parameter int RAM_DEPTH = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] instr,
  output logic [9:0] pc,
  output logic       cpu_halted
);

  localparam int AW = $clog2(RAM_DEPTH);

  typedef enum logic [2:0] {
    OP_RTYPE = 3'b000,
    OP_MISC  = 3'b001,
    OP_BNE   = 3'b010,
    OP_ADDI  = 3'b011,
    OP_JUMP  = 3'b100,
    OP_BEQ   = 3'b101,
    OP_LOAD  = 3'b110,
    OP_STORE = 3'b111
  } op_e;

  logic [9:0] r_pc;
  logic       r_halted;
  logic [9:0] r_regs [8];
  logic [9:0] r_ram  [RAM_DEPTH];

  op_e        w_op;
  logic [1:0] w_rs;
  logic [1:0] w_rt;
  logic [1:0] w_imm;
  logic       w_bank;
  logic [6:0] w_jaddr;
  logic [9:0] w_a;
  logic [9:0] w_b;
  logic [9:0] w_zext;
  logic [9:0] w_sext;
  logic [9:0] w_addr;
  logic [9:0] w_ram_rd;
  logic       w_slt;
  logic [9:0] w_next_pc;
  logic       w_reg_we;
  logic [9:0] w_reg_wd;
  logic       w_ram_we;
  logic       w_halt;

  assign w_op     = op_e'(instr[9:7]);
  assign w_rs     = instr[6:5];
  assign w_rt     = instr[4:3];
  assign w_bank   = instr[2];
  assign w_imm    = instr[1:0];
  assign w_jaddr  = instr[6:0];
  assign w_a      = r_regs[{w_bank, w_rs}];
  assign w_b      = r_regs[{w_bank, w_rt}];
  assign w_zext   = {8'd0, w_imm};
  assign w_sext   = {{8{w_imm[1]}}, w_imm};
  assign w_addr   = w_a + w_sext;
  assign w_ram_rd = r_ram[w_addr[AW-1:0]];
  assign w_slt    = ($signed(w_a) < $signed(w_b));

  assign pc         = r_pc;
  assign cpu_halted = r_halted;

  // Decode and execute: next pc, register write-back and RAM write strobe
  always_comb begin
    w_next_pc = r_pc + 10'd1;
    w_reg_we  = 1'b0;
    w_reg_wd  = 10'd0;
    w_ram_we  = 1'b0;
    w_halt    = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_reg_we = 1'b1;
        case (w_imm)
          2'b00:   w_reg_wd = w_a + w_b;
          2'b01:   w_reg_wd = w_a - w_b;
          2'b10:   w_reg_wd = {9'd0, w_slt};
          default: w_reg_wd = ~(w_a & w_b);
        endcase
      end
      OP_MISC: begin
        case (w_imm)
          2'b00: begin
            w_reg_we = 1'b1;
            w_reg_wd = {1'b0, w_a[9:1]};
          end
          2'b01: begin
            w_reg_we = 1'b1;
            w_reg_wd = {w_a[8:0], 1'b0};
          end
          2'b10: begin
            w_halt    = 1'b1;
            w_next_pc = r_pc;
          end
          default: w_reg_we = 1'b0;
        endcase
      end
      OP_BNE: begin
        if (w_a != w_b) w_next_pc = r_pc + w_zext;
        else            w_next_pc = r_pc + 10'd1;
      end
      OP_ADDI: begin
        w_reg_we = 1'b1;
        w_reg_wd = w_a + w_zext;
      end
      OP_JUMP: w_next_pc = {{3{w_jaddr[6]}}, w_jaddr};
      OP_BEQ: begin
        if (w_a == w_b) w_next_pc = r_pc + w_zext;
        else            w_next_pc = r_pc + 10'd1;
      end
      OP_LOAD: begin
        w_reg_we = 1'b1;
        w_reg_wd = w_ram_rd;
      end
      OP_STORE: w_ram_we = 1'b1;
      default:  w_ram_we = 1'b0;
    endcase
    // A halted core ignores instr entirely and holds every piece of state
    if (r_halted) begin
      w_next_pc = r_pc;
      w_reg_we  = 1'b0;
      w_ram_we  = 1'b0;
      w_halt    = 1'b0;
    end else begin
      w_halt    = w_halt;
    end
  end

  // Architectural state: pc, sticky halt flag and register file
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc     <= 10'd0;
      r_halted <= 1'b0;
      for (int i = 0; i < 8; i++) r_regs[i] <= 10'd0;
    end else begin
      r_pc <= w_next_pc;
      if (w_halt)   r_halted <= 1'b1;
      if (w_reg_we) r_regs[{w_bank, w_rt}] <= w_reg_wd;
    end
  end

  // Data RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (rst && w_ram_we) r_ram[w_addr[AW-1:0]] <= w_b;
  end

endmodule

// File: tb/tb_cpu_10bits.sv
// Directed-vector bench for cpu_10bits: expected pc/halt per retired instruction go through a
// scoreboard queue checked by an independent monitor; register/RAM state is checked hierarchically.
module tb_cpu_10bits;

  logic       clk;
  logic       rst;
  logic [9:0] instr;
  logic [9:0] pc;
  logic       cpu_halted;

  int total = 0;
  int bad   = 0;

  logic [10:0] exp_q [$];
  logic [10:0] mon_e;

  localparam logic [9:0] NOP = 10'b001_00_00_0_11;

  cpu_10bits dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .pc         (pc),
    .cpu_halted (cpu_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: after each rising edge, compare the retired state against the oldest expectation
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      total++;
      if ({cpu_halted, pc} !== mon_e) begin
        bad++;
        $display("FAIL retire: got halted=%0b pc=%h, expected halted=%0b pc=%h",
                 cpu_halted, pc, mon_e[10], mon_e[9:0]);
      end
    end
  end

  task automatic step(input logic [9:0] ins, input logic [9:0] epc, input logic eh);
    @(negedge clk);
    instr = ins;
    exp_q.push_back({eh, epc});
    @(posedge clk);
  endtask

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    int waits;
    rst   = 1'b0;
    instr = NOP;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pc", pc, 10'd0);
    chk("reset_halt", {9'd0, cpu_halted}, 10'd0);
    chk("reset_r1", dut.r_regs[1], 10'd0);
    #1 rst = 1'b1;

    step(NOP, 10'd1, 1'b0);
    step(NOP, 10'd2, 1'b0);
    step(NOP, 10'd3, 1'b0);

    step(10'b011_00_01_0_11, 10'd4, 1'b0);
    step(10'b011_01_01_0_10, 10'd5, 1'b0);
    #2 chk("addi_r1", dut.r_regs[1], 10'd5);
    step(10'b000_01_10_0_00, 10'd6, 1'b0);
    step(10'b000_01_10_0_00, 10'd7, 1'b0);
    #2 chk("add_r2", dut.r_regs[2], 10'd10);

    step(10'b011_00_01_1_11, 10'd8, 1'b0);
    #2 chk("bank1_r1", dut.r_regs[5], 10'd3);
    chk("bank0_r1_kept", dut.r_regs[1], 10'd5);

    step(10'b011_00_00_0_10, 10'd9, 1'b0);
    step(10'b011_11_01_0_11, 10'd10, 1'b0);
    #2 chk("setup_r0", dut.r_regs[0], 10'd2);
    chk("setup_r1", dut.r_regs[1], 10'd3);
    step(10'b000_00_01_0_10, 10'd11, 1'b0);
    #2 chk("slt_2_3", dut.r_regs[1], 10'd1);
    step(10'b000_11_01_0_01, 10'd12, 1'b0);
    #2 chk("sub_0_1", dut.r_regs[1], 10'h3FF);
    step(10'b000_01_00_0_10, 10'd13, 1'b0);
    #2 chk("slt_signed", dut.r_regs[0], 10'd1);
    step(10'b000_01_01_0_11, 10'd14, 1'b0);
    #2 chk("nand_ones", dut.r_regs[1], 10'd0);

    step(10'b011_01_01_0_11, 10'd15, 1'b0);
    step(10'b011_01_01_0_11, 10'd16, 1'b0);
    step(10'b011_01_01_0_01, 10'd17, 1'b0);
    #2 chk("setup_r1_7", dut.r_regs[1], 10'd7);
    step(10'b111_00_01_0_01, 10'd18, 1'b0);
    #2 chk("store_ram2", dut.r_ram[2], 10'd7);
    step(10'b110_00_10_0_01, 10'd19, 1'b0);
    #2 chk("load_r2", dut.r_regs[2], 10'd7);
    step(10'b111_11_01_0_11, 10'd20, 1'b0);
    #2 chk("store_wrap", dut.r_ram[1023], 10'd7);
    step(10'b110_11_00_0_11, 10'd21, 1'b0);
    #2 chk("load_wrap", dut.r_regs[0], 10'd7);

    step(10'b100_0000100, 10'd4, 1'b0);
    step(10'b101_11_11_0_10, 10'd6, 1'b0);
    step(10'b100_0000100, 10'd4, 1'b0);
    step(10'b010_11_11_0_10, 10'd5, 1'b0);
    step(10'b010_00_11_0_11, 10'd8, 1'b0);
    step(10'b101_00_11_0_11, 10'd9, 1'b0);
    step(10'b100_1111111, 10'h3FF, 1'b0);
    step(NOP, 10'd0, 1'b0);
    step(10'b100_0000101, 10'd5, 1'b0);
    step(10'b100_0001001, 10'd9, 1'b0);

    step(10'b001_00_00_0_10, 10'd9, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) step(10'b011_01_01_0_11, 10'd9, 1'b1);
      else            step(10'b111_11_11_0_11, 10'd9, 1'b1);
    end
    #2 chk("halt_no_regwr", dut.r_regs[1], 10'd7);
    chk("halt_no_ramwr", dut.r_ram[1023], 10'd7);

    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_pc", pc, 10'd0);
    chk("async_rst_halt", {9'd0, cpu_halted}, 10'd0);
    for (int i = 0; i < 8; i++) chk("async_rst_reg", dut.r_regs[i], 10'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    step(NOP, 10'd1, 1'b0);
    step(NOP, 10'd2, 1'b0);
    #2 chk("ram_kept", dut.r_ram[2], 10'd7);

    waits = 0;
    while (exp_q.size() != 0 && waits < 5) begin
      @(posedge clk);
      #2;
      waits++;
    end
    chk("queue_drained", 10'(exp_q.size()), 10'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
